// File: rtl/pe_feed_pkg.sv
// Shared types and constants for the PE16_8 row feeder: FSM state encoding,
// datapath widths, lane-mode encoding, skew-line entry layout and the
// absolute-value helpers used by the row converter.
package pe_feed_pkg;

   localparam int DATA_W = 16;
   localparam int SIGN_W = 2;

   localparam logic MODE_8  = 1'b1;
   localparam logic MODE_16 = 1'b0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } feed_state_t;

   // One slot of the skew line: exactly what a PE row consumes in a cycle.
   typedef struct packed {
      logic [DATA_W-1:0] mag;
      logic [SIGN_W-1:0] sign;
      logic              mode;
      logic              en;
   } feed_entry_t;

   // Two's-complement magnitude of a byte; 0x80 maps to 0x80, which is exact
   // when read as unsigned.
   function automatic logic [7:0] absByte(input logic [7:0] v);
      return v[7] ? (~v + 8'd1) : v;
   endfunction

   // Two's-complement magnitude of a 16-bit word; 0x8000 maps to 0x8000.
   function automatic logic [15:0] absWord(input logic [15:0] v);
      return v[15] ? (~v + 16'd1) : v;
   endfunction

endpackage

// File: rtl/pe_row_feeder_if.sv
// Activation stream into the feeder: valid/ready handshake plus one packed
// signed vector carrying ROWS 16-bit elements, row r at [16r+15:16r].
interface pe_row_feeder_if import pe_feed_pkg::*; #(parameter int ROWS = 4);

   logic                   s_valid;
   logic                   s_ready;
   logic [ROWS*DATA_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/sm16_8_conv.sv
// Combinational two's-complement to magnitude + 2-bit sign converter for one
// PE row. In 16-bit mode the word is converted whole and both sign bits carry
// the word sign; in dual 8-bit mode each byte is converted on its own.
// Build option: define PE_FEED_SAT_EN to clamp most-negative inputs to the
// largest positive magnitude (0x7FFF, or 0x7F per byte lane) instead of
// passing the exact unsigned magnitude 0x8000 / 0x80.
module sm16_8_conv import pe_feed_pkg::*; (
   input  logic              mode,
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] mag,
   output logic [SIGN_W-1:0] sign
);

   logic [15:0] magWord;
   logic [7:0]  magHi;
   logic [7:0]  magLo;

   // Compute both interpretations, optionally clamp, then select by lane mode.
   always_comb begin
      magWord = absWord(x);
      magHi   = absByte(x[15:8]);
      magLo   = absByte(x[7:0]);
`ifdef PE_FEED_SAT_EN
      if (x == 16'h8000) begin
         magWord = 16'h7FFF;
      end
      if (x[15:8] == 8'h80) begin
         magHi = 8'h7F;
      end
      if (x[7:0] == 8'h80) begin
         magLo = 8'h7F;
      end
`else
      magWord = magWord;
`endif
      if (mode == MODE_8) begin
         mag  = {magHi, magLo};
         sign = {x[15], x[7]};
      end else begin
         mag  = magWord;
         sign = {x[15], x[15]};
      end
   end

endmodule

// File: rtl/pe_row_feeder.sv
// Left-column feeder for the PE16_8 systolic array. Accepts signed activation
// vectors, converts every row element to magnitude + sign form and delays row
// r by r extra register stages so the array sees the diagonal skew. A tile
// FSM counts accepted vectors, flushes the skew line with bubbles and pulses
// done. All state moves on the falling clock edge to match the PE array.
// Build option: PE_FEED_SAT_EN (see sm16_8_conv) selects saturation of
// most-negative inputs.
module pe_row_feeder import pe_feed_pkg::*; #(
   parameter int ROWS  = 4,
   parameter int LEN_W = 16
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   start,
   input  logic [LEN_W-1:0]       cfg_len,
   input  logic                   cfg_mode,
   pe_row_feeder_if.slave         s,
   output logic [ROWS*DATA_W-1:0] x_mag,
   output logic [ROWS*SIGN_W-1:0] x_sign,
   output logic [ROWS-1:0]        x_mode,
   output logic [ROWS-1:0]        x_en,
   output logic                   busy,
   output logic                   done
);

   // Flush counter must count ROWS bubble cycles.
   localparam int FL_W = $clog2(ROWS + 1);

   feed_state_t      state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             mode_q, mode_d;
   logic [FL_W-1:0]  flush_q, flush_d;
   logic             accept;

   // Ready is a pure decode of the registered state, never of s_valid.
   assign s.s_ready = (state_q == STREAM);
   assign accept    = s.s_valid && (state_q == STREAM);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

   // Tile control register: state, vector count, latched config, flush count.
   always_ff @(negedge clk or posedge res) begin
      if (res) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         mode_q  <= MODE_16;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         mode_q  <= mode_d;
         flush_q <= flush_d;
      end
   end

   // Next-state logic: latch config on start, count accepts, then inject
   // exactly ROWS bubble cycles so the last row drains before done.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      mode_d  = mode_q;
      flush_d = flush_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d  = cfg_len;
               mode_d = cfg_mode;
               cnt_d  = '0;
               if (cfg_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (accept) begin
               cnt_d = cnt_q + LEN_W'(1);
               if ((cnt_q + LEN_W'(1)) == len_q) begin
                  flush_d = '0;
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (flush_q == FL_W'(ROWS - 1)) begin
               state_d = DONE;
            end else begin
               flush_d = flush_q + FL_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_W-1:0] convMag;
      logic [SIGN_W-1:0] convSign;
      feed_entry_t       head;
      feed_entry_t       line_q [0:r];

      sm16_8_conv u_conv (
         .mode (mode_q),
         .x    (s.s_data[r*DATA_W +: DATA_W]),
         .mag  (convMag),
         .sign (convSign)
      );

      // Entry entering this row's skew line: converted element on accept,
      // otherwise a bubble that still carries the tile mode.
      always_comb begin
         head      = '0;
         head.mode = mode_q;
         if (accept) begin
            head.en   = 1'b1;
            head.mag  = convMag;
            head.sign = convSign;
         end
      end

      // Skew line for row r: r+1 registers that shift every cycle.
      always_ff @(negedge clk or posedge res) begin
         if (res) begin
            for (int k = 0; k <= r; k++) begin
               line_q[k] <= '0;
            end
         end else begin
            line_q[0] <= head;
            for (int k = 1; k <= r; k++) begin
               line_q[k] <= line_q[k-1];
            end
         end
      end

      assign x_mag[r*DATA_W +: DATA_W]  = line_q[r].mag;
      assign x_sign[r*SIGN_W +: SIGN_W] = line_q[r].sign;
      assign x_mode[r]                  = line_q[r].mode;
      assign x_en[r]                    = line_q[r].en;
   end

endmodule
